// File: rtl/pwm_capture_pkg.sv
// Shared definitions for pwm_capture: register map, CTRL/STATUS bit positions
// and measurement FSM encoding.
package pwm_capture_pkg;

  localparam logic [4:0] ADDR_CTRL   = 5'd0;
  localparam logic [4:0] ADDR_STATUS = 5'd1;
  localparam logic [4:0] ADDR_PERIOD = 5'd2;
  localparam logic [4:0] ADDR_HIGH   = 5'd3;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;
  localparam int CTRL_IE  = 2;

  localparam int STAT_VALID = 0;
  localparam int STAT_OVF   = 1;
  localparam int STAT_LEVEL = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_HIGH_PH = 2'd2,
    ST_LOW_PH  = 2'd3
  } state_e;

endpackage

// File: rtl/pwm_capture_sync_edge_detect.sv
// Synchroniser for the asynchronous PWM input, with single-cycle rise/fall
// pulses derived from the synchronised level.
module sync_edge_detect #(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STG-1:0] sync_q;
  logic                prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], din};
      prev   <= sync_q[SYNC_STG-1];
    end
  end

  assign level = sync_q[SYNC_STG-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time capture with an Avalon-MM register file.
// Define PWM_CAPTURE_IRQ_EN to add the CTRL.IE bit and a level interrupt on VALID.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int SYNC_STG = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  slave_address,
  input  logic        slave_read,
  input  logic        slave_write,
  output logic [31:0] slave_readdata,
  input  logic [31:0] slave_writedata,
  input  logic [3:0]  slave_byteenable,
  input  logic        pwm_in,
  output logic        led,
  output logic        irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             level, rise, fall;
  state_e           state;
  logic             en, valid, ovf, ie;
  logic [CNT_W-1:0] cnt, hcnt, period, high;
  logic             ctrl_wr, clr, measuring, cap, ovf_hit;
  logic [31:0]      rd_mux;
  logic             unused;

  sync_edge_detect #(.SYNC_STG(SYNC_STG)) u_sync (
    .clk  (clk),
    .rst  (reset),
    .din  (pwm_in),
    .level(level),
    .rise (rise),
    .fall (fall)
  );

  assign led    = level;
  assign unused = ^{slave_byteenable, slave_writedata};

  assign ctrl_wr   = slave_write && (slave_address == ADDR_CTRL);
  assign clr       = ctrl_wr && slave_writedata[CTRL_CLR];
  assign measuring = (state == ST_HIGH_PH) || (state == ST_LOW_PH);
  assign cap       = en && (state == ST_LOW_PH) && rise;
  // Saturation without the closing rise: a fall at the limit still cannot
  // produce a representable period, so it aborts the measurement too.
  assign ovf_hit   = en && measuring && !cap && (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      hcnt   <= '0;
      period <= '0;
      high   <= '0;
    end else begin
      if (rise)           cnt <= CNT_ONE;
      else if (measuring) cnt <= cnt + CNT_ONE;

      if (!en) begin
        state <= ST_IDLE;
      end else if (ovf_hit) begin
        state <= ST_ARM;
      end else begin
        case (state)
          ST_IDLE: state <= ST_ARM;
          ST_ARM:  if (rise) state <= ST_HIGH_PH;
          ST_HIGH_PH: begin
            if (fall) begin
              hcnt  <= cnt;
              state <= ST_LOW_PH;
            end
          end
          ST_LOW_PH: begin
            if (rise) begin
              period <= cnt;
              high   <= hcnt;
              state  <= ST_HIGH_PH;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // CLR takes priority over a same-cycle capture or overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en    <= 1'b0;
      valid <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (ctrl_wr) en <= slave_writedata[CTRL_EN];
      valid <= !clr && (valid || cap);
      ovf   <= !clr && (ovf || ovf_hit);
    end
  end

`ifdef PWM_CAPTURE_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        ie <= 1'b0;
    else if (ctrl_wr) ie <= slave_writedata[CTRL_IE];
  end
  assign irq = ie & valid;
`else
  assign ie  = 1'b0;
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (slave_address)
      ADDR_CTRL: begin
        rd_mux[CTRL_EN] = en;
        rd_mux[CTRL_IE] = ie;
      end
      ADDR_STATUS: begin
        rd_mux[STAT_VALID] = valid;
        rd_mux[STAT_OVF]   = ovf;
        rd_mux[STAT_LEVEL] = level;
      end
      ADDR_PERIOD: rd_mux = 32'(period);
      ADDR_HIGH:   rd_mux = 32'(high);
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           slave_readdata <= '0;
    else if (slave_read) slave_readdata <= rd_mux;
  end

endmodule
